// File: rtl/vss_pkg.sv
// Shared types and constants for the vector sweep sequencer:
// the state encoding, the MISR polynomial and the Gray-code helper.
package vss_pkg;

  typedef enum logic [2:0] {
    VSS_IDLE   = 3'd0,
    VSS_APPLY  = 3'd1,
    VSS_SETTLE = 3'd2,
    VSS_SAMPLE = 3'd3,
    VSS_EMIT   = 3'd4,
    VSS_DONE   = 3'd5
  } vss_state_e;

  localparam logic [15:0] POLY = 16'h1021;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/vector_sweep_sequencer_if.sv
// Record stream carrying each (vector, response) pair from the sequencer
// to its sink over a valid/ready handshake.
interface vector_sweep_sequencer_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 1
);
  logic             rec_valid;
  logic             rec_ready;
  logic [IN_W-1:0]  rec_vec;
  logic [OUT_W-1:0] rec_resp;

  modport master (output rec_valid, output rec_vec, output rec_resp, input rec_ready);
  modport slave  (input rec_valid, input rec_vec, input rec_resp, output rec_ready);
endinterface

// File: rtl/vss_misr.sv
// Multiple-input signature register compacting DUT responses; instantiated
// by the sequencer only when VSS_MISR_EN is defined.
module vss_misr
  import vss_pkg::*;
#(
  parameter int SIG_W = 16,
  parameter int OUT_W = 1
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  localparam logic [SIG_W-1:0] POLY_W = SIG_W'(POLY);

  logic [SIG_W-1:0] sig_r;
  logic [SIG_W-1:0] next_sig_s;

  always_comb begin
    next_sig_s = {sig_r[SIG_W-2:0], 1'b0}
               ^ (sig_r[SIG_W-1] ? POLY_W : {SIG_W{1'b0}})
               ^ SIG_W'(din);
  end

  // Clear wins over the shift so a new sweep always starts from zero.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      sig_r <= {SIG_W{1'b0}};
    end else if (clr) begin
      sig_r <= {SIG_W{1'b0}};
    end else if (en) begin
      sig_r <= next_sig_s;
    end else begin
      sig_r <= sig_r;
    end
  end

  assign sig = sig_r;

endmodule

// File: rtl/vector_sweep_sequencer.sv
// Exhaustive binary/Gray stimulus sweep with per-vector settle, response
// sampling, record streaming and optional MISR (enabled by VSS_MISR_EN).
module vector_sweep_sequencer
  import vss_pkg::*;
#(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1,
  parameter int SIG_W  = 16
) (
  input  logic                      CK,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      gray_mode,
  output logic [IN_W-1:0]           stim_o,
  input  logic [OUT_W-1:0]          resp_i,
  vector_sweep_sequencer_if.master  rec,
  output logic                      busy,
  output logic                      done,
  output logic [SIG_W-1:0]          signature
);

  localparam logic [2:0] ST_IDLE   = VSS_IDLE;
  localparam logic [2:0] ST_APPLY  = VSS_APPLY;
  localparam logic [2:0] ST_SETTLE = VSS_SETTLE;
  localparam logic [2:0] ST_SAMPLE = VSS_SAMPLE;
  localparam logic [2:0] ST_EMIT   = VSS_EMIT;
  localparam logic [2:0] ST_DONE   = VSS_DONE;

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit SKIP_SETTLE = (SETTLE == 0);
  // One extra index bit so the final vector is detected rather than wrapped.
  localparam logic [IN_W:0] LAST_IDX = {1'b0, {IN_W{1'b1}}};

  logic [2:0]       state_r, next_s;
  logic [IN_W:0]    idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic             gray_r;
  logic [IN_W-1:0]  stim_r, vec_r;
  logic [OUT_W-1:0] resp_r;
  logic             valid_r, busy_r, done_r;
  logic             accept_s, sample_s, xfer_s, last_s;
  logic [IN_W-1:0]  apply_vec_s;

  assign accept_s    = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start;
  assign sample_s    = (state_r == ST_SAMPLE);
  assign xfer_s      = (state_r == ST_EMIT) && rec.rec_ready;
  assign last_s      = (idx_r == LAST_IDX);
  assign apply_vec_s = gray_r ? IN_W'(bin2gray(32'(idx_r))) : idx_r[IN_W-1:0];

  // Next-state decode for the sweep FSM.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) next_s = ST_APPLY;
        else       next_s = state_r;
      end
      ST_APPLY: begin
        if (SKIP_SETTLE) next_s = ST_SAMPLE;
        else             next_s = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_r <= CNT_ONE) next_s = ST_SAMPLE;
        else                  next_s = ST_SETTLE;
      end
      ST_SAMPLE: next_s = ST_EMIT;
      ST_EMIT: begin
        if (rec.rec_ready) next_s = last_s ? ST_DONE : ST_APPLY;
        else               next_s = ST_EMIT;
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // State plus status flags registered from the next state.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      valid_r <= (next_s == ST_EMIT);
      busy_r  <= (next_s == ST_APPLY) || (next_s == ST_SETTLE) ||
                 (next_s == ST_SAMPLE) || (next_s == ST_EMIT);
      done_r  <= (next_s == ST_DONE);
    end
  end

  // Index, settle counter, stimulus and record registers.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      idx_r  <= {(IN_W+1){1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      gray_r <= 1'b0;
      stim_r <= {IN_W{1'b0}};
      vec_r  <= {IN_W{1'b0}};
      resp_r <= {OUT_W{1'b0}};
    end else begin
      if (accept_s) begin
        idx_r  <= {(IN_W+1){1'b0}};
        gray_r <= gray_mode;
      end else if (xfer_s && !last_s) begin
        idx_r <= idx_r + {{IN_W{1'b0}}, 1'b1};
      end else begin
        idx_r <= idx_r;
      end

      if (state_r == ST_APPLY) begin
        stim_r <= apply_vec_s;
        cnt_r  <= SETTLE_LD;
      end else if (state_r == ST_SETTLE) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end

      if (sample_s) begin
        vec_r  <= stim_r;
        resp_r <= resp_i;
      end else begin
        vec_r  <= vec_r;
        resp_r <= resp_r;
      end
    end
  end

`ifdef VSS_MISR_EN
  vss_misr #(
    .SIG_W (SIG_W),
    .OUT_W (OUT_W)
  ) u_misr (
    .CK    (CK),
    .reset (reset),
    .clr   (accept_s),
    .en    (sample_s),
    .din   (resp_i),
    .sig   (signature)
  );
`else
  assign signature = {SIG_W{1'b0}};
`endif

  assign stim_o        = stim_r;
  assign rec.rec_valid = valid_r;
  assign rec.rec_vec   = vec_r;
  assign rec.rec_resp  = resp_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_vector_sweep_sequencer.sv
// Scoreboard bench: SETTLE=1 and SETTLE=0 instances swept side by side,
// covering binary/Gray order, backpressure, start-while-busy and mid-sweep reset.
module tb_vector_sweep_sequencer;

  localparam int IN_W  = 3;
  localparam int OUT_W = 1;
  localparam int SIG_W = 16;
  localparam int NVEC  = 8;

  logic CK = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic gray_mode = 1'b0;
  logic [IN_W-1:0]  stim0, stim1;
  logic [OUT_W-1:0] resp0, resp1;
  logic busy0, done0, busy1, done1;
  logic [SIG_W-1:0] sig0, sig1;
  int checks = 0;
  int errors = 0;
  int resp_mode = 0;

  typedef struct {
    logic [IN_W-1:0]  vec;
    logic [OUT_W-1:0] resp;
  } rec_t;
  rec_t q0[$];
  rec_t q1[$];

  vector_sweep_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) rec0 ();
  vector_sweep_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) rec1 ();
  assign rec1.rec_ready = 1'b1;

  always #5 CK = ~CK;

  function automatic logic fake_dut(input logic [IN_W-1:0] v, input int mode);
    if (mode == 0)      return 1'b1;
    else if (mode == 1) return 1'b0;
    else                return ^v;
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, r};
  endfunction

  assign resp0 = fake_dut(stim0, resp_mode);
  assign resp1 = fake_dut(stim1, resp_mode);

  vector_sweep_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1), .SIG_W(SIG_W)) dut0 (
    .CK(CK), .reset(reset), .start(start), .gray_mode(gray_mode),
    .stim_o(stim0), .resp_i(resp0), .rec(rec0),
    .busy(busy0), .done(done0), .signature(sig0)
  );

  vector_sweep_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(0), .SIG_W(SIG_W)) dut1 (
    .CK(CK), .reset(reset), .start(start), .gray_mode(gray_mode),
    .stim_o(stim1), .resp_i(resp1), .rec(rec1),
    .busy(busy1), .done(done1), .signature(sig1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_stim"},  32'(stim0), 32'd0);
    check_eq({tag, "_valid"}, 32'(rec0.rec_valid), 32'd0);
    check_eq({tag, "_vec"},   32'(rec0.rec_vec), 32'd0);
    check_eq({tag, "_resp"},  32'(rec0.rec_resp), 32'd0);
    check_eq({tag, "_busy"},  32'(busy0), 32'd0);
    check_eq({tag, "_done"},  32'(done0), 32'd0);
    check_eq({tag, "_sig"},   32'(sig0), 32'd0);
  endtask

  task automatic run_sweep(input logic gm, input int mode, input int stall_vec,
                           input int stall_len, input int pulse_cyc, input int abort_cyc);
    logic [15:0] exp_sig;
    logic [IN_W-1:0] v;
    int cyc, n0, n1, stalled;
    bit seen0, seen1;
    rec_t r;
    exp_sig = 16'h0000;
    n0 = 0; n1 = 0; stalled = 0; seen0 = 1'b0; seen1 = 1'b0;
    q0.delete(); q1.delete();
    resp_mode = mode;
    for (int k = 0; k < NVEC; k++) begin
      v = gm ? IN_W'(k ^ (k >> 1)) : IN_W'(k);
      r.vec = v;
      r.resp = fake_dut(v, mode);
      q0.push_back(r);
      q1.push_back(r);
      exp_sig = misr_step(exp_sig, r.resp);
    end
`ifndef VSS_MISR_EN
    exp_sig = 16'h0000;
`endif
    @(negedge CK);
    start = 1'b1;
    gray_mode = gm;
    rec0.rec_ready = 1'b1;
    @(posedge CK);
    cyc = 1;
    while (cyc < 200 && !(seen0 && seen1)) begin
      @(negedge CK);
      start = (cyc == pulse_cyc);
      if (cyc == abort_cyc) begin
        reset = 1'b1;
        #1;
        check_idle_outputs("abort");
        check_eq("abort_count", 32'(n0), 32'd4);
        @(negedge CK);
        reset = 1'b0;
        start = 1'b0;
        @(negedge CK);
        return;
      end
      if (!seen0 && done0) begin
        seen0 = 1'b1;
        check_eq("done0_cycle", 32'(cyc), 32'(1 + NVEC * 4 + stall_len));
        check_eq("sig0", 32'(sig0), 32'(exp_sig));
        check_eq("count0", 32'(n0), 32'(NVEC));
        check_eq("busy0_done", 32'(busy0), 32'd0);
      end
      if (!seen1 && done1) begin
        seen1 = 1'b1;
        check_eq("done1_cycle", 32'(cyc), 32'(1 + NVEC * 3));
        check_eq("sig1", 32'(sig1), 32'(exp_sig));
        check_eq("count1", 32'(n1), 32'(NVEC));
      end
      if (rec0.rec_valid) begin
        check_eq("busy0_emit", 32'(busy0), 32'd1);
        if (q0.size() == 0) begin
          check_eq("rec0_extra", 32'd1, 32'd0);
        end else begin
          check_eq("rec0_vec", 32'(rec0.rec_vec), 32'(q0[0].vec));
          check_eq("rec0_resp", 32'(rec0.rec_resp), 32'(q0[0].resp));
          if (n0 == stall_vec && stalled < stall_len) begin
            rec0.rec_ready = 1'b0;
            stalled++;
          end else begin
            rec0.rec_ready = 1'b1;
            void'(q0.pop_front());
            n0++;
          end
        end
      end else begin
        rec0.rec_ready = 1'b1;
      end
      if (rec1.rec_valid) begin
        if (q1.size() == 0) begin
          check_eq("rec1_extra", 32'd1, 32'd0);
        end else begin
          check_eq("rec1_vec", 32'(rec1.rec_vec), 32'(q1[0].vec));
          check_eq("rec1_resp", 32'(rec1.rec_resp), 32'(q1[0].resp));
          void'(q1.pop_front());
          n1++;
        end
      end
      @(posedge CK);
      cyc++;
    end
    if (!seen0) check_eq("done0_timeout", 32'd0, 32'd1);
    if (!seen1) check_eq("done1_timeout", 32'd0, 32'd1);
    check_eq("q0_left", 32'(q0.size()), 32'd0);
    start = 1'b0;
    repeat (3) @(negedge CK);
    check_eq("sig0_hold", 32'(sig0), 32'(exp_sig));
    check_eq("done0_hold", 32'(done0), 32'd1);
  endtask

  initial begin
    rec0.rec_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge CK);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge CK);
    check_idle_outputs("idle");

    run_sweep(1'b0, 0, -1, 0, -1, -1);   // binary, response 1
    run_sweep(1'b1, 1, -1, 0, -1, -1);   // Gray, response 0
    run_sweep(1'b0, 2, 2, 5, -1, -1);    // backpressure on vector 2
    run_sweep(1'b0, 2, -1, 0, 10, -1);   // start pulse while busy
    run_sweep(1'b1, 2, -1, 0, -1, 18);   // reset during vector 4 settle
    run_sweep(1'b1, 2, -1, 0, -1, -1);   // fresh sweep after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
